div_issue_ctrl: RTL and testbench

- EX-stage controller directly upstream of the multi-cycle divider (`div`).
- Accepts DIV/DIVU from the EX stage, latches operands and drives the divider's start/signed/annul handshake.
- Stalls the pipeline until the divider reports ready, then presents the remainder (HI) and quotient (LO) with a HI/LO write enable until the instruction leaves EX.
- Handles flush (annul), divider drain and a watchdog timeout.

---
 rtl/div_issue_ctrl_pkg.sv | 21 ++
 rtl/div_issue_ctrl.sv | 77 +++++++
 tb/tb_div_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: state encodings, divider handshake constants and defaults for the divide issue controller.
package div_issue_ctrl_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam int MAX_WAIT_DEF     = 40;
    localparam int DRAIN_CYCLES_DEF = 2;

    typedef struct packed {
        logic        sgn;
        logic [31:0] op1;
        logic [31:0] op2;
    } div_ops_t;
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues DIV/DIVU to the multi-cycle divider, stalls EX until the result is ready,
// then presents HI/LO; handles flush annul, divider drain and a watchdog.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int MAX_WAIT     = MAX_WAIT_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        signed_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);
    logic [1:0] state, state_nx;
    logic [5:0] cnt;
    div_ops_t   ops;
    logic       accept, flush_wait, ready_wait, expire, drain_done, done_exit;

    assign accept     = state == S_IDLE && div_req_i && !flush_i;
    assign flush_wait = state == S_WAIT && flush_i;
    assign ready_wait = state == S_WAIT && !flush_i && div_ready_i == DIV_RESULT_READY;
    // ready on the last permitted cycle still counts as a good result
    assign expire     = state == S_WAIT && !flush_i && div_ready_i != DIV_RESULT_READY
                        && cnt == 6'(MAX_WAIT - 1);
    assign drain_done = state == S_DRAIN && cnt == 6'(DRAIN_CYCLES - 1);
    assign done_exit  = state == S_DONE && (flush_i || !stall_i);

    always_comb begin
        state_nx = accept                   ? S_WAIT  :
                   (flush_wait || expire)   ? S_DRAIN :
                   ready_wait               ? S_DONE  :
                   (done_exit || drain_done) ? S_IDLE : state;
    end

    // one counter serves both the WAIT watchdog and the DRAIN length; it restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            ops   <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 6'd0 : cnt + 6'd1;
            if (accept)
                ops <= '{sgn: signed_i, op1: rs_data_i, op2: rt_data_i};
            if (ready_wait)
                {hi_o, lo_o} <= div_result_i;
        end
    end

    assign div_start_o  = (state == S_WAIT) ? DIV_START : DIV_STOP;
    assign div_signed_o = ops.sgn;
    assign div_op1_o    = ops.op1;
    assign div_op2_o    = ops.op2;
    assign div_annul_o  = flush_wait;
    assign stall_req_o  = !rst && (state == S_WAIT || accept || (state == S_DRAIN && div_req_i));
    assign hilo_we_o    = state == S_DONE && !flush_i;
    assign timeout_o    = expire;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: table-driven, directed and randomized checks of div_issue_ctrl against a behavioural divider.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int MAXW = 40;

    logic        clk = 1'b0, rst = 1'b1;
    logic        div_req = 1'b0, sgn = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [31:0] rs = '0, rt = '0;
    logic [63:0] div_result;
    logic        div_ready;
    logic        div_start, div_signed, div_annul, stall_req, hilo_we, timeout;
    logic [31:0] div_op1, div_op2, hi, lo;

    int checks = 0, errors = 0;
    int div_lat = 3;
    int dcnt;

    div_issue_ctrl #(.MAX_WAIT(MAXW), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .div_req_i(div_req), .signed_i(sgn),
        .rs_data_i(rs), .rt_data_i(rt), .flush_i(flush), .stall_i(stall),
        .div_result_i(div_result), .div_ready_i(div_ready),
        .div_start_o(div_start), .div_signed_o(div_signed), .div_op1_o(div_op1),
        .div_op2_o(div_op2), .div_annul_o(div_annul), .stall_req_o(stall_req),
        .hilo_we_o(hilo_we), .hi_o(hi), .lo_o(lo), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    // behavioural divider: result ready after div_lat cycles of start, cleared whenever start drops
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt       <= 0;
            div_ready  <= DIV_RESULT_NOT_READY;
            div_result <= '0;
        end else if (div_start != DIV_START || div_annul) begin
            dcnt      <= 0;
            div_ready <= DIV_RESULT_NOT_READY;
        end else if (dcnt == div_lat - 1) begin
            div_ready  <= DIV_RESULT_READY;
            div_result <= ref_div(div_signed, div_op1, div_op2);
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance until stall_req drops (DONE cycle); n = stall cycles seen after the current one
    task automatic wait_done(input string nm, input logic [31:0] eh, input logic [31:0] el, output int n);
        n = 0;
        while (n < 100) begin
            tick();
            #1;
            if (!stall_req) break;
            n++;
        end
        chk({nm, "_done_reached"}, 64'(n < 100), 64'd1);
        chk({nm, "_hilo_we"}, 64'(hilo_we), 64'd1);
        chk({nm, "_hilo"}, {hi, lo}, {eh, el});
        chk({nm, "_start_done"}, 64'(div_start), 64'd0);
    endtask

    task automatic leave_done(input string nm);
        tick();
        div_req = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk({nm, "_we_after"}, 64'(hilo_we), 64'd0);
        chk({nm, "_stall_after"}, 64'(stall_req), 64'd0);
    endtask

    task automatic run_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el, input int hold);
        int n;
        tick();
        div_req = 1'b1; sgn = s; rs = a; rt = b; div_lat = lat; flush = 1'b0; stall = 1'b0;
        #1;
        chk({nm, "_req_stall"}, 64'(stall_req), 64'd1);
        wait_done(nm, eh, el, n);
        chk({nm, "_stall_cycles"}, 64'(n + 1), 64'(lat + 2));
        if (hold > 0) begin
            stall = 1'b1;
            for (int i = 1; i <= hold; i++) begin
                tick();
                if (i == hold) stall = 1'b0;
                #1;
                chk({nm, "_hold_we"}, 64'(hilo_we), 64'd1);
                chk({nm, "_hold_hilo"}, {hi, lo}, {eh, el});
                chk({nm, "_hold_start"}, 64'(div_start), 64'd0);
            end
        end
        leave_done(nm);
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] hi, lo;
        int          hold;
    } vec_t;

    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k;
        logic [63:0] e;
        logic s;
        logic [31:0] a, b;

        vt[0] = '{1'b0, 32'd100, 32'd7, 5, 32'd2, 32'd14, 0};
        vt[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 12, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
        vt[2] = '{1'b1, 32'd12345, 32'd0, 3, 32'd0, 32'd0, 0};
        vt[3] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 8, 32'd1, 32'hFFFF_FFFD, 3};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 30, 32'd0, 32'hFFFF_FFFF, 0};

        #2;
        chk("reset_outputs", {div_start, div_signed, div_annul, stall_req, hilo_we, timeout}, 64'd0);
        chk("reset_regs", {hi, lo}, 64'd0);
        chk("reset_ops", {div_op1, div_op2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].lat, vt[i].hi, vt[i].lo, vt[i].hold);

        // flush on the 10th WAIT cycle, with the next DIV already waiting
        tick();
        div_req = 1'b1; sgn = 1'b0; rs = 32'd1000; rt = 32'd9; div_lat = 30;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 10) flush = 1'b1;
            #1;
            if (i == 9) chk("flush_no_annul_before", 64'(div_annul), 64'd0);
        end
        chk("flush_annul", 64'(div_annul), 64'd1);
        chk("flush_start_that_cycle", 64'(div_start), 64'd1);
        tick();
        flush = 1'b0; sgn = 1'b1; rs = 32'd50; rt = 32'd6; div_lat = 2;
        #1;
        chk("drain1_annul", 64'(div_annul), 64'd0);
        chk("drain1_start", 64'(div_start), 64'd0);
        chk("drain1_stall", 64'(stall_req), 64'd1);
        tick();
        #1;
        chk("drain2_start", 64'(div_start), 64'd0);
        chk("drain2_stall", 64'(stall_req), 64'd1);
        tick();
        #1;
        chk("idle_accept_start", 64'(div_start), 64'd0);
        chk("idle_accept_stall", 64'(stall_req), 64'd1);
        wait_done("after_flush", 32'd2, 32'd8, n);
        chk("after_flush_ops", {div_op1, div_op2}, {32'd50, 32'd6});
        chk("after_flush_signed", 64'(div_signed), 64'd1);
        leave_done("after_flush");

        // flush while presenting the result suppresses the write
        tick();
        div_req = 1'b1; sgn = 1'b0; rs = 32'd9; rt = 32'd2; div_lat = 2;
        wait_done("done_flush", 32'd1, 32'd4, n);
        flush = 1'b1;
        #1;
        chk("done_flush_we", 64'(hilo_we), 64'd0);
        leave_done("done_flush");

        // watchdog: divider never becomes ready
        tick();
        div_req = 1'b1; sgn = 1'b0; rs = 32'd5; rt = 32'd3; div_lat = 1000;
        k = 0;
        while (k < 100) begin
            tick();
            #1;
            k++;
            if (timeout) break;
            if (hilo_we) chk("wd_no_we", 64'(hilo_we), 64'd0);
        end
        chk("wd_cycle", 64'(k), 64'(MAXW));
        tick();
        div_req = 1'b0;
        #1;
        chk("wd_drain1", {div_start, timeout, hilo_we}, 64'd0);
        tick();
        #1;
        chk("wd_drain2", {div_start, timeout, hilo_we}, 64'd0);
        tick();
        div_req = 1'b1; rs = 32'd20; rt = 32'd3; div_lat = 4;
        #1;
        chk("wd_idle_accept", 64'(stall_req), 64'd1);
        wait_done("wd_next", 32'd2, 32'd6, n);
        leave_done("wd_next");

        // async reset in the middle of WAIT
        tick();
        div_req = 1'b1; rs = 32'd77; rt = 32'd5; div_lat = 1000;
        tick(); tick(); tick();
        #2;
        chk("pre_rst_start", 64'(div_start), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {div_start, div_annul, stall_req, hilo_we, timeout, div_signed}, 64'd0);
        chk("async_rst_ops", {div_op1, div_op2}, 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        div_req = 1'b0;

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            e = ref_div(s, a, b);
            run_op($sformatf("rnd%0d", i), s, a, b, int'($urandom_range(1, 30)), e[63:32], e[31:0],
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
